// File: rtl/sec_lock_pkg.sv
// Shared types for the secure-lock initiator sequencer: response codes, access levels, FSM states.
package sec_lock_pkg;

  localparam logic [1:0] LVL_NONE  = 2'd0;
  localparam logic [1:0] LVL_RW    = 2'd1;
  localparam logic [1:0] LVL_ADMIN = 2'd2;

  typedef enum logic [2:0] {
    ST_OK          = 3'd0,
    ST_WR_ERR      = 3'd1,
    ST_TIMEOUT     = 3'd2,
    ST_UNLOCK_FAIL = 3'd3,
    ST_LVL_FAIL    = 3'd4,
    ST_RELOCK_FAIL = 3'd5
  } status_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_AUTH,
    S_AUTH_WAIT,
    S_UNLOCK,
    S_UNLOCK_WAIT,
    S_SET_LVL,
    S_LVL_WAIT,
    S_WRITE,
    S_WRITE_WAIT,
    S_RELOCK,
    S_RELOCK_WAIT,
    S_RESP
  } state_e;

  // Every wait state is entered from a non-wait state, so "not waiting" doubles as the timer reload.
  function automatic logic is_wait_state(state_e s);
    return (s == S_AUTH_WAIT) || (s == S_UNLOCK_WAIT) || (s == S_LVL_WAIT) ||
           (s == S_WRITE_WAIT) || (s == S_RELOCK_WAIT);
  endfunction

endpackage

// File: rtl/sec_seq_timer.sv
// Saturating timeout down-counter: reloads to TIMEOUT_CYC on clear, counts down while enabled,
// and flags expiry at zero (terminal count) without wrapping.
module sec_seq_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = LOAD;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/sec_unlock_seq.sv
// Host-side sequencer for the secure register lock protocol: key, unlock, level, write, relock.
// Build option: define SEC_SEQ_RETRY_EN to retry failed writes up to MAX_RETRY times.
//
// state        | meaning
// IDLE         | cmd_ready high, waiting for a command
// AUTH         | key_valid pulse with latched key
// AUTH_WAIT    | one settle cycle, then branch on target lock status
// UNLOCK       | lock_req pulse to clear the lock
// UNLOCK_WAIT  | wait for toggle with locked=0
// SET_LVL      | access_lvl_valid pulse with commanded level
// LVL_WAIT     | wait for target level to match
// WRITE        | reg_write_req pulse with data
// WRITE_WAIT   | wait for write_success / error_flag
// RELOCK       | lock_req pulse to re-engage the lock
// RELOCK_WAIT  | wait for toggle with locked=1
// RESP         | rsp_valid pulse with coded status
module sec_unlock_seq
  import sec_lock_pkg::*;
#(
  parameter int REG_WIDTH      = 32,
  parameter int PASSWORD_WIDTH = 32,
  parameter int TIMEOUT_CYC    = 16,
  parameter int MAX_RETRY      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [PASSWORD_WIDTH-1:0] cmd_key,
  input  logic [1:0]                cmd_lvl,
  input  logic [REG_WIDTH-1:0]      cmd_data,
  input  logic                      cmd_relock,
  output logic                      rsp_valid,
  output logic [2:0]                rsp_status,
  output logic [PASSWORD_WIDTH-1:0] key_in,
  output logic                      key_valid,
  output logic [1:0]                set_access_lvl,
  output logic                      access_lvl_valid,
  output logic                      lock_req,
  output logic                      reg_write_req,
  output logic [REG_WIDTH-1:0]      reg_write_data,
  input  logic                      locked,
  input  logic [1:0]                access_level,
  input  logic                      write_success,
  input  logic                      error_flag,
  input  logic                      lock_state_update
);

  state_e                    state_q, state_d;
  status_e                   status_d, rsp_status_q;
  logic                      cmd_ready_q, rsp_valid_q;
  logic                      key_valid_q, lock_req_q, access_lvl_valid_q, reg_write_req_q;
  logic [PASSWORD_WIDTH-1:0] key_in_q;
  logic [1:0]                set_access_lvl_q, cmd_lvl_q;
  logic [REG_WIDTH-1:0]      reg_write_data_q, cmd_data_q;
  logic                      cmd_relock_q;
  logic                      accept, in_wait, tmr_expired;
  logic                      retry_inc;

  assign accept  = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;
  assign in_wait = is_wait_state(state_q);

  sec_seq_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .clr_i     (!in_wait),
    .en_i      (in_wait),
    .expired_o (tmr_expired)
  );

`ifdef SEC_SEQ_RETRY_EN
  localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RCW-1:0] retry_cnt_q;
  logic           retry_ok;
  assign retry_ok = (int'(retry_cnt_q) < MAX_RETRY);
`else
  logic retry_ok;
  logic unused_retry;
  assign retry_ok     = 1'b0;
  assign unused_retry = (MAX_RETRY > 0);
`endif

  always_comb begin
    state_d   = state_q;
    status_d  = ST_OK;
    retry_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd_lvl == LVL_NONE) begin
            state_d  = S_RESP;
            status_d = ST_LVL_FAIL;
          end else begin
            state_d = S_AUTH;
          end
        end
      end
      S_AUTH:      state_d = S_AUTH_WAIT;
      S_AUTH_WAIT: state_d = locked ? S_UNLOCK : S_SET_LVL;
      S_UNLOCK:    state_d = S_UNLOCK_WAIT;
      S_UNLOCK_WAIT: begin
        if (lock_state_update && !locked) begin
          state_d = S_SET_LVL;
        end else if (lock_state_update || tmr_expired) begin
          state_d  = S_RESP;
          status_d = ST_UNLOCK_FAIL;
        end
      end
      S_SET_LVL:   state_d = S_LVL_WAIT;
      S_LVL_WAIT: begin
        if (access_level == cmd_lvl_q) begin
          state_d = S_WRITE;
        end else if (tmr_expired) begin
          state_d  = S_RESP;
          status_d = ST_LVL_FAIL;
        end
      end
      S_WRITE:     state_d = S_WRITE_WAIT;
      S_WRITE_WAIT: begin
        // error_flag is checked first so a simultaneous success is treated as a failure
        if (error_flag) begin
          if (retry_ok) begin
            state_d   = S_AUTH;
            retry_inc = 1'b1;
          end else begin
            state_d  = S_RESP;
            status_d = ST_WR_ERR;
          end
        end else if (write_success) begin
          if (cmd_relock_q) begin
            state_d = S_RELOCK;
          end else begin
            state_d  = S_RESP;
            status_d = ST_OK;
          end
        end else if (tmr_expired) begin
          state_d  = S_RESP;
          status_d = ST_TIMEOUT;
        end
      end
      S_RELOCK:    state_d = S_RELOCK_WAIT;
      S_RELOCK_WAIT: begin
        if (lock_state_update) begin
          state_d  = S_RESP;
          status_d = locked ? ST_OK : ST_RELOCK_FAIL;
        end else if (tmr_expired) begin
          state_d  = S_RESP;
          status_d = ST_RELOCK_FAIL;
        end
      end
      S_RESP:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each strobe is high exactly while its state is.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= S_IDLE;
      cmd_ready_q        <= 1'b1;
      rsp_valid_q        <= 1'b0;
      rsp_status_q       <= ST_OK;
      key_valid_q        <= 1'b0;
      lock_req_q         <= 1'b0;
      access_lvl_valid_q <= 1'b0;
      reg_write_req_q    <= 1'b0;
      key_in_q           <= '0;
      set_access_lvl_q   <= '0;
      reg_write_data_q   <= '0;
      cmd_lvl_q          <= '0;
      cmd_data_q         <= '0;
      cmd_relock_q       <= 1'b0;
`ifdef SEC_SEQ_RETRY_EN
      retry_cnt_q        <= '0;
`endif
    end else begin
      state_q            <= state_d;
      cmd_ready_q        <= (state_d == S_IDLE);
      rsp_valid_q        <= (state_d == S_RESP);
      key_valid_q        <= (state_d == S_AUTH);
      lock_req_q         <= (state_d == S_UNLOCK) || (state_d == S_RELOCK);
      access_lvl_valid_q <= (state_d == S_SET_LVL);
      reg_write_req_q    <= (state_d == S_WRITE);
      if (accept) begin
        cmd_lvl_q    <= cmd_lvl;
        cmd_data_q   <= cmd_data;
        cmd_relock_q <= cmd_relock;
        if (cmd_lvl != LVL_NONE) begin
          key_in_q <= cmd_key;
        end
      end
      if (state_d == S_SET_LVL) begin
        set_access_lvl_q <= cmd_lvl_q;
      end
      if (state_d == S_WRITE) begin
        reg_write_data_q <= cmd_data_q;
      end
      if (state_d == S_RESP) begin
        rsp_status_q <= status_d;
      end
      if (state_d == S_IDLE) begin
        key_in_q         <= '0;
        set_access_lvl_q <= '0;
        reg_write_data_q <= '0;
      end
`ifdef SEC_SEQ_RETRY_EN
      if (accept) begin
        retry_cnt_q <= '0;
      end else if (retry_inc) begin
        retry_cnt_q <= retry_cnt_q + 1'b1;
      end
`endif
    end
  end

  assign cmd_ready        = cmd_ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_status       = rsp_status_q;
  assign key_in           = key_in_q;
  assign key_valid        = key_valid_q;
  assign set_access_lvl   = set_access_lvl_q;
  assign access_lvl_valid = access_lvl_valid_q;
  assign lock_req         = lock_req_q;
  assign reg_write_req    = reg_write_req_q;
  assign reg_write_data   = reg_write_data_q;

endmodule

// File: tb/tb_sec_unlock_seq.sv
// Bench for sec_unlock_seq: behavioural lock target, command driver, and a response scoreboard.
module tb_sec_unlock_seq;

  localparam int RW = 32;
  localparam int PW = 32;
  localparam int TO = 16;
  localparam int MR = 2;
  localparam logic [31:0] GOOD_KEY = 32'hDEADBEEF;
  localparam logic [31:0] BAD_KEY  = 32'h12345678;
`ifdef SEC_SEQ_RETRY_EN
  localparam int N_ATT = MR + 1;
`else
  localparam int N_ATT = 1;
`endif
  localparam int EM_NORMAL = 0, EM_ERR = 1, EM_BOTH = 2, EM_HOLD = 3;

  logic          clk, rst;
  logic          cmd_valid, cmd_ready, cmd_relock;
  logic [PW-1:0] cmd_key;
  logic [1:0]    cmd_lvl;
  logic [RW-1:0] cmd_data;
  logic          rsp_valid;
  logic [2:0]    rsp_status;
  logic [PW-1:0] key_in;
  logic          key_valid, access_lvl_valid, lock_req, reg_write_req;
  logic [1:0]    set_access_lvl;
  logic [RW-1:0] reg_write_data;
  logic          locked = 1'b1;
  logic [1:0]    access_level = 2'd0;
  logic          write_success = 1'b0, error_flag = 1'b0, lock_state_update = 1'b0;

  sec_unlock_seq #(
    .REG_WIDTH(RW), .PASSWORD_WIDTH(PW), .TIMEOUT_CYC(TO), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key), .cmd_lvl(cmd_lvl),
    .cmd_data(cmd_data), .cmd_relock(cmd_relock),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status),
    .key_in(key_in), .key_valid(key_valid), .set_access_lvl(set_access_lvl),
    .access_lvl_valid(access_lvl_valid), .lock_req(lock_req), .reg_write_req(reg_write_req),
    .reg_write_data(reg_write_data), .locked(locked), .access_level(access_level),
    .write_success(write_success), .error_flag(error_flag), .lock_state_update(lock_state_update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  status;
    int          n_key, n_lock, n_lvl, n_wr;
    int          lat_src;   // 0 none, 1 first lock_req, 2 first level strobe, 3 first write
    bit          chk_order;
    logic [1:0]  lvl;
    logic [31:0] key;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t mk(input logic [2:0] st, input int nk, input int nl, input int nv,
                              input int nw, input int lat, input bit ord, input logic [1:0] lvl,
                              input logic [31:0] key, input logic [31:0] data);
    exp_t e;
    e.status = st; e.n_key = nk; e.n_lock = nl; e.n_lvl = nv; e.n_wr = nw;
    e.lat_src = lat; e.chk_order = ord; e.lvl = lvl; e.key = key; e.data = data;
    return e;
  endfunction

  // Lock target model: toggles lock two cycles after an authorised lock_req, answers writes next cycle.
  bit          auth_ok = 1'b0;
  int          lk_pend = 0;
  bit          wr_pend = 1'b0;
  logic [31:0] wr_data_l = '0;
  logic [31:0] reg_data = '0;
  int          err_mode = EM_NORMAL;
  int          preset_seq = 0, preset_seen = 0;
  bit          preset_locked = 1'b1;

  always @(negedge clk) begin
    lock_state_update = 1'b0;
    write_success     = 1'b0;
    error_flag        = 1'b0;
    if (preset_seq != preset_seen) begin
      preset_seen  = preset_seq;
      locked       = preset_locked;
      access_level = 2'd0;
      auth_ok      = 1'b0;
      lk_pend      = 0;
      wr_pend      = 1'b0;
    end
    if (lk_pend != 0) begin
      lk_pend--;
      if (lk_pend == 0) begin
        locked            = ~locked;
        lock_state_update = 1'b1;
      end
    end
    if (key_valid) auth_ok = (key_in == GOOD_KEY);
    if (lock_req && auth_ok) lk_pend = 2;
    if (access_lvl_valid && auth_ok && !locked) access_level = set_access_lvl;
    if (wr_pend) begin
      wr_pend = 1'b0;
      case (err_mode)
        EM_ERR:  error_flag = 1'b1;
        EM_BOTH: begin error_flag = 1'b1; write_success = 1'b1; end
        default: begin
          if (auth_ok && !locked && access_level != 2'd0) begin
            write_success = 1'b1;
            reg_data      = wr_data_l;
          end else begin
            error_flag = 1'b1;
          end
        end
      endcase
    end
    if (reg_write_req) begin
      wr_pend   = (err_mode != EM_HOLD);
      wr_data_l = reg_write_data;
    end
  end

  // Monitor: counts strobes per command and scores each response against the queue head.
  int          cyc = 0;
  int          m_key, m_lock, m_lvl, m_wr;
  int          t_key, t_lock, t_lvl, t_wr;
  logic [1:0]  lvl_seen;
  logic [31:0] key_at_lvl, wr_seen;
  int          n_rsp_total = 0;
  exp_t        e_mon;

  always @(negedge clk) begin
    cyc++;
    if (rst || (cmd_valid && cmd_ready)) begin
      m_key = 0; m_lock = 0; m_lvl = 0; m_wr = 0;
      t_key = -1; t_lock = -1; t_lvl = -1; t_wr = -1;
    end
    if (!rst) begin
      if (key_valid) begin m_key++; if (t_key < 0) t_key = cyc; end
      if (lock_req) begin m_lock++; if (t_lock < 0) t_lock = cyc; end
      if (access_lvl_valid) begin
        m_lvl++; if (t_lvl < 0) t_lvl = cyc;
        lvl_seen = set_access_lvl; key_at_lvl = key_in;
      end
      if (reg_write_req) begin
        m_wr++; if (t_wr < 0) t_wr = cyc;
        wr_seen = reg_write_data;
      end
      if (rsp_valid) begin
        n_rsp_total++;
        if (sb.size() == 0) begin
          check_val("rsp_unexpected", 1, 0);
        end else begin
          e_mon = sb.pop_front();
          check_val("status", rsp_status, e_mon.status);
          check_val("n_key", m_key, e_mon.n_key);
          check_val("n_lock", m_lock, e_mon.n_lock);
          check_val("n_lvl", m_lvl, e_mon.n_lvl);
          check_val("n_wr", m_wr, e_mon.n_wr);
          if (e_mon.n_lvl > 0) begin
            check_val("lvl_val", lvl_seen, e_mon.lvl);
            check_val("key_at_lvl", key_at_lvl, e_mon.key);
          end
          if (e_mon.n_wr > 0) check_val("wr_data", wr_seen, e_mon.data);
          if (e_mon.chk_order)
            check_val("strobe_order", (t_key < t_lock) && (t_lock < t_lvl) && (t_lvl < t_wr), 1);
          if (e_mon.lat_src == 1) check_val("lat_unlock", cyc - t_lock, TO + 2);
          if (e_mon.lat_src == 2) check_val("lat_lvl", cyc - t_lvl, TO + 2);
          if (e_mon.lat_src == 3) check_val("lat_write", cyc - t_wr, TO + 2);
        end
      end
    end
  end

  task automatic preset(input bit lk);
    preset_locked = lk;
    preset_seq++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] key, input logic [1:0] lvl, input logic [31:0] data,
                      input bit relock, input bit push, input exp_t e);
    int w;
    w = 0;
    while (!cmd_ready && w < 100) begin @(posedge clk); #1; w++; end
    if (!cmd_ready) check_val("ready_timeout", 0, 1);
    if (push) sb.push_back(e);
    cmd_key = key; cmd_lvl = lvl; cmd_data = data; cmd_relock = relock;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      check_val("rsp_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  int  rsp_before;
  bit  wr_hit;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_key = '0; cmd_lvl = '0; cmd_data = '0; cmd_relock = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check_val("rst_ready", cmd_ready, 1);
    check_val("rst_strobes", {key_valid, lock_req, access_lvl_valid, reg_write_req, rsp_valid}, 0);
    check_val("rst_outs", {key_in, reg_write_data, set_access_lvl, rsp_status}, 0);

    // locked target, full unlock path
    preset(1'b1);
    send(GOOD_KEY, 2'd1, 32'hA5A5_0001, 1'b0, 1'b1,
         mk(3'd0, 1, 1, 1, 1, 0, 1'b1, 2'd1, GOOD_KEY, 32'hA5A5_0001));
    wait_rsp();
    check_val("t1_reg_data", reg_data, 32'hA5A5_0001);
    check_val("t1_unlocked", locked, 0);
    check_val("key_idle", key_in, 0);

    // relock after write
    preset(1'b1);
    send(GOOD_KEY, 2'd1, 32'hA5A5_0001, 1'b1, 1'b1,
         mk(3'd0, 1, 2, 1, 1, 0, 1'b1, 2'd1, GOOD_KEY, 32'hA5A5_0001));
    wait_rsp();
    check_val("t2_relocked", locked, 1);

    // wrong key on locked target: no toggle, unlock timeout
    preset(1'b1);
    send(BAD_KEY, 2'd1, 32'h0BAD_0BAD, 1'b0, 1'b1,
         mk(3'd3, 1, 1, 0, 0, 1, 1'b0, 2'd1, BAD_KEY, 32'h0));
    wait_rsp();
    check_val("t3_still_locked", locked, 1);
    check_val("t3_reg_kept", reg_data, 32'hA5A5_0001);

    // already unlocked target, admin level
    preset(1'b0);
    send(GOOD_KEY, 2'd2, 32'h0000_BEEF, 1'b0, 1'b1,
         mk(3'd0, 1, 0, 1, 1, 0, 1'b0, 2'd2, GOOD_KEY, 32'h0000_BEEF));
    wait_rsp();
    check_val("t4_reg_data", reg_data, 32'h0000_BEEF);

    // wrong key on unlocked target: level never changes
    preset(1'b0);
    send(BAD_KEY, 2'd2, 32'h1111_2222, 1'b0, 1'b1,
         mk(3'd4, 1, 0, 1, 0, 2, 1'b0, 2'd2, BAD_KEY, 32'h0));
    wait_rsp();

    // forced write error
    err_mode = EM_ERR;
    preset(1'b1);
    send(GOOD_KEY, 2'd1, 32'h3333_4444, 1'b0, 1'b1,
         mk(3'd1, N_ATT, 1, N_ATT, N_ATT, 0, 1'b0, 2'd1, GOOD_KEY, 32'h3333_4444));
    wait_rsp();

    // success and error together: error wins
    err_mode = EM_BOTH;
    preset(1'b0);
    send(GOOD_KEY, 2'd1, 32'h5555_6666, 1'b0, 1'b1,
         mk(3'd1, N_ATT, 0, N_ATT, N_ATT, 0, 1'b0, 2'd1, GOOD_KEY, 32'h5555_6666));
    wait_rsp();

    // target never answers the write
    err_mode = EM_HOLD;
    preset(1'b0);
    send(GOOD_KEY, 2'd1, 32'h7777_8888, 1'b0, 1'b1,
         mk(3'd2, 1, 0, 1, 1, 3, 1'b0, 2'd1, GOOD_KEY, 32'h7777_8888));
    wait_rsp();

    // level 0 rejected at accept
    err_mode = EM_NORMAL;
    send(GOOD_KEY, 2'd0, 32'h9999_AAAA, 1'b0, 1'b1,
         mk(3'd4, 0, 0, 0, 0, 0, 1'b0, 2'd0, GOOD_KEY, 32'h0));
    wait_rsp();
    check_val("lvl0_key_idle", key_in, 0);

    // reset while in WRITE_WAIT
    err_mode = EM_HOLD;
    preset(1'b0);
    send(GOOD_KEY, 2'd1, 32'hCAFE_0001, 1'b0, 1'b0,
         mk(3'd0, 0, 0, 0, 0, 0, 1'b0, 2'd0, 32'h0, 32'h0));
    wr_hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (reg_write_req) begin wr_hit = 1'b1; break; end
    end
    check_val("rst_wr_seen", wr_hit, 1);
    @(posedge clk); #1;
    rsp_before = n_rsp_total;
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("midrst_strobes", {key_valid, lock_req, access_lvl_valid, reg_write_req, rsp_valid}, 0);
    check_val("midrst_key", key_in, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("midrst_ready", cmd_ready, 1);
    repeat (30) @(posedge clk);
    #1;
    check_val("midrst_no_rsp", n_rsp_total - rsp_before, 0);

    // normal operation after the abandoned sequence
    err_mode = EM_NORMAL;
    preset(1'b1);
    send(GOOD_KEY, 2'd1, 32'h1234_5678, 1'b0, 1'b1,
         mk(3'd0, 1, 1, 1, 1, 0, 1'b1, 2'd1, GOOD_KEY, 32'h1234_5678));
    wait_rsp();
    check_val("t11_reg_data", reg_data, 32'h1234_5678);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
